// File: rtl/regfile_mp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp_pkg
// Description : Shared definitions for the multi-port register file:
//               bulk-clear FSM state encoding and a clog2 helper used to
//               size address fields.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_mp_pkg;

    // Bulk-clear engine states
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_CLEAR = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    // Ceiling log2; returns 0 for values <= 1
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_wr_arb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wr_arb
// Description : Write arbiter for a single register-file entry. Scans all
//               write ports and selects the highest-indexed enabled port
//               whose address matches this entry.
// Ports       : i_wr_ok  - per-port qualified write enable (in range, idle)
//               i_waddr  - flattened write addresses, port k at [k*AW +: AW]
//               i_wdata  - flattened write data, port k at [k*WIDTH +: WIDTH]
//               o_hit    - this entry is written this cycle
//               o_data   - data from the winning port
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wr_arb
    import regfile_mp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NW    = 4,
    parameter int AW    = 5,
    parameter int IDX   = 0
) (
    input  logic [NW-1:0]       i_wr_ok,
    input  logic [NW*AW-1:0]    i_waddr,
    input  logic [NW*WIDTH-1:0] i_wdata,
    output logic                o_hit,
    output logic [WIDTH-1:0]    o_data
);

    localparam logic [AW-1:0] c_IDX = AW'(IDX);

    // Ascending scan: a later (higher-index) match overrides earlier ones,
    // which gives the highest port the win.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        for (int k = 0; k < NW; k++) begin
            if (i_wr_ok[k] && (i_waddr[k*AW +: AW] == c_IDX)) begin
                o_hit  = 1'b1;
                o_data = i_wdata[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp
// Description : Parametrised multi-write / multi-read register file with
//               priority write arbitration, optional write-to-read bypass,
//               optional hardwired-zero entry 0, registered write-collision
//               flag and a sequenced bulk-clear engine.
// Ports       : clk, reset (async, active high)
//               we/waddr/wdata   - NW write ports (flattened)
//               raddr/rdata      - NR combinational read ports (flattened)
//               clr_start        - request bulk clear
//               busy             - clear engine running
//               clr_done         - one-cycle pulse at clear completion
//               wr_conflict      - registered same-address write collision
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NW       = 4,
    parameter int NR       = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0,
    localparam int AW      = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NW-1:0]       we,
    input  logic [NW*AW-1:0]    waddr,
    input  logic [NW*WIDTH-1:0] wdata,
    input  logic [NR*AW-1:0]    raddr,
    output logic [NR*WIDTH-1:0] rdata,
    input  logic                clr_start,
    output logic                busy,
    output logic                clr_done,
    output logic                wr_conflict
);

    localparam logic [AW-1:0] c_LAST = AW'(DEPTH - 1);

    logic [1:0]                   r_state;
    logic [AW-1:0]                r_cnt;
    logic                         r_busy;
    logic                         r_clr_done;
    logic                         r_wr_conflict;
    logic [NW-1:0]                w_wr_ok;
    logic                         w_collide;
    logic [DEPTH-1:0][WIDTH-1:0]  w_mem;

    // A write port is effective only when enabled, in range and the clear
    // engine is not running.
    for (genvar k = 0; k < NW; k++) begin : g_wr_ok
        assign w_wr_ok[k] = we[k] && !r_busy && (32'(waddr[k*AW +: AW]) < DEPTH);
    end

    // Any pair of effective ports aiming at the same entry is a collision.
    always_comb begin
        w_collide = 1'b0;
        for (int k = 0; k < NW; k++) begin
            for (int m = k + 1; m < NW; m++) begin
                if (w_wr_ok[k] && w_wr_ok[m] &&
                    (waddr[k*AW +: AW] == waddr[m*AW +: AW])) begin
                    w_collide = 1'b1;
                end
            end
        end
    end

    // Clear engine and registered status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= c_ST_IDLE;
            r_cnt         <= '0;
            r_busy        <= 1'b0;
            r_clr_done    <= 1'b0;
            r_wr_conflict <= 1'b0;
        end else begin
            // w_collide already excludes busy cycles via w_wr_ok
            r_wr_conflict <= w_collide;
            case (r_state)
                c_ST_IDLE: begin
                    r_clr_done <= 1'b0;
                    if (clr_start) begin
                        r_state <= c_ST_CLEAR;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                c_ST_CLEAR: begin
                    if (r_cnt == c_LAST) begin
                        r_state    <= c_ST_DONE;
                        r_busy     <= 1'b0;
                        r_clr_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_ST_DONE: begin
                    r_clr_done <= 1'b0;
                    r_state    <= c_ST_IDLE;
                end
                default: begin
                    r_state    <= c_ST_IDLE;
                    r_busy     <= 1'b0;
                    r_clr_done <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign clr_done    = r_clr_done;
    assign wr_conflict = r_wr_conflict;

    // Storage: one arbiter and one register per entry
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        // Entry 0 stays at its reset value of zero when hardwired
        localparam bit c_WRITABLE = !((ZERO_REG != 0) && (i == 0));

        logic             w_hit;
        logic [WIDTH-1:0] w_data;
        logic [WIDTH-1:0] r_q;

        regfile_wr_arb #(
            .WIDTH (WIDTH),
            .NW    (NW),
            .AW    (AW),
            .IDX   (i)
        ) u_arb (
            .i_wr_ok (w_wr_ok),
            .i_waddr (waddr),
            .i_wdata (wdata),
            .o_hit   (w_hit),
            .o_data  (w_data)
        );

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_q <= '0;
            end else if (r_busy && (r_cnt == AW'(i))) begin
                r_q <= '0;
            end else if (c_WRITABLE && w_hit) begin
                r_q <= w_data;
            end
        end

        assign w_mem[i] = r_q;
    end

    // Read ports: stored value, then bypass, then the zero-entry override
    for (genvar j = 0; j < NR; j++) begin : g_rd
        logic [AW-1:0]    w_ra;
        logic [WIDTH-1:0] w_rd;

        assign w_ra = raddr[j*AW +: AW];

        always_comb begin
            w_rd = '0;
            if (32'(w_ra) < DEPTH) begin
                w_rd = w_mem[w_ra];
            end
            // Ascending scan so the highest matching port is forwarded,
            // matching the value that will be stored at the edge.
            if ((BYPASS != 0) && !r_busy) begin
                for (int k = 0; k < NW; k++) begin
                    if (w_wr_ok[k] && (waddr[k*AW +: AW] == w_ra)) begin
                        w_rd = wdata[k*WIDTH +: WIDTH];
                    end
                end
            end
            if ((ZERO_REG != 0) && (w_ra == '0)) begin
                w_rd = '0;
            end
        end

        assign rdata[j*WIDTH +: WIDTH] = w_rd;
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_mp
// Description : Directed self-checking bench for regfile_mp. Instance A is
//               32x32, no bypass, no zero entry. Instance B is 20 entries,
//               bypass on, hardwired zero entry.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

    logic clk;

    // Instance A signals
    logic         a_reset;
    logic [3:0]   a_we;
    logic [19:0]  a_waddr;
    logic [127:0] a_wdata;
    logic [9:0]   a_raddr;
    logic [63:0]  a_rdata;
    logic         a_clr_start;
    logic         a_busy;
    logic         a_clr_done;
    logic         a_wr_conflict;

    // Instance B signals
    logic         b_reset;
    logic [3:0]   b_we;
    logic [19:0]  b_waddr;
    logic [127:0] b_wdata;
    logic [9:0]   b_raddr;
    logic [63:0]  b_rdata;
    logic         b_clr_start;
    logic         b_busy;
    logic         b_clr_done;
    logic         b_wr_conflict;

    int checks = 0;
    int errors = 0;

    regfile_mp #(
        .WIDTH(32), .DEPTH(32), .NW(4), .NR(2), .BYPASS(0), .ZERO_REG(0)
    ) dut_a (
        .clk         (clk),
        .reset       (a_reset),
        .we          (a_we),
        .waddr       (a_waddr),
        .wdata       (a_wdata),
        .raddr       (a_raddr),
        .rdata       (a_rdata),
        .clr_start   (a_clr_start),
        .busy        (a_busy),
        .clr_done    (a_clr_done),
        .wr_conflict (a_wr_conflict)
    );

    regfile_mp #(
        .WIDTH(32), .DEPTH(20), .NW(4), .NR(2), .BYPASS(1), .ZERO_REG(1)
    ) dut_b (
        .clk         (clk),
        .reset       (b_reset),
        .we          (b_we),
        .waddr       (b_waddr),
        .wdata       (b_wdata),
        .raddr       (b_raddr),
        .rdata       (b_rdata),
        .clr_start   (b_clr_start),
        .busy        (b_busy),
        .clr_done    (b_clr_done),
        .wr_conflict (b_wr_conflict)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_wr(input int k, input logic [4:0] ad, input logic [31:0] d);
        a_we[k]              = 1'b1;
        a_waddr[k*5 +: 5]    = ad;
        a_wdata[k*32 +: 32]  = d;
    endtask

    task automatic b_wr(input int k, input logic [4:0] ad, input logic [31:0] d);
        b_we[k]              = 1'b1;
        b_waddr[k*5 +: 5]    = ad;
        b_wdata[k*32 +: 32]  = d;
    endtask

    initial begin
        int          busy_cnt;
        int          done_cnt;
        logic [31:0] acc;

        a_reset = 1'b1; a_we = '0; a_waddr = '0; a_wdata = '0; a_raddr = '0; a_clr_start = 1'b0;
        b_reset = 1'b1; b_we = '0; b_waddr = '0; b_wdata = '0; b_raddr = '0; b_clr_start = 1'b0;

        // ---------------- Reset state ----------------
        #2;
        check("rst_busy",     {31'd0, a_busy},        32'd0);
        check("rst_done",     {31'd0, a_clr_done},    32'd0);
        check("rst_conflict", {31'd0, a_wr_conflict}, 32'd0);
        check("rst_rdata",    a_rdata[31:0],          32'd0);
        tick();
        tick();
        a_reset = 1'b0;
        b_reset = 1'b0;
        tick();

        // ---------------- Single write, no bypass ----------------
        a_wr(0, 5'd5, 32'hDEADBEEF);
        a_raddr[4:0] = 5'd5;
        #1;
        check("wr_before_edge", a_rdata[31:0], 32'd0);
        tick();
        a_we = '0;
        #1;
        check("wr_after_edge", a_rdata[31:0], 32'hDEADBEEF);
        check("wr_no_conflict", {31'd0, a_wr_conflict}, 32'd0);

        // ---------------- Four-way collision ----------------
        a_we = '0;
        a_wr(0, 5'd7, 32'd1);
        a_wr(1, 5'd7, 32'd2);
        a_wr(2, 5'd7, 32'd3);
        a_wr(3, 5'd7, 32'd4);
        tick();
        a_we = '0;
        a_wr(0, 5'd8,  32'h10);
        a_wr(1, 5'd9,  32'h11);
        a_wr(2, 5'd10, 32'h12);
        a_wr(3, 5'd11, 32'h13);
        a_raddr[4:0] = 5'd7;
        a_raddr[9:5] = 5'd10;
        #1;
        check("coll_flag",      {31'd0, a_wr_conflict}, 32'd1);
        check("coll_winner",    a_rdata[31:0],  32'd4);
        check("nobypass_read",  a_rdata[63:32], 32'd0);
        tick();
        a_we = '0;
        #1;
        check("coll_clear",     {31'd0, a_wr_conflict}, 32'd0);
        check("distinct_write", a_rdata[63:32], 32'h12);

        // ---------------- Bypass with priority (instance B) ----------------
        b_we = '0;
        b_wr(0, 5'd4, 32'hA);
        b_wr(2, 5'd3, 32'h55);
        b_wr(3, 5'd4, 32'hB);
        b_raddr[4:0] = 5'd4;
        b_raddr[9:5] = 5'd3;
        #1;
        check("byp_prio",  b_rdata[31:0],  32'hB);
        check("byp_port2", b_rdata[63:32], 32'h55);
        tick();
        b_we = '0;
        #1;
        check("byp_stored_prio", b_rdata[31:0],  32'hB);
        check("byp_stored",      b_rdata[63:32], 32'h55);
        check("byp_conflict",    {31'd0, b_wr_conflict}, 32'd1);

        // ---------------- Hardwired zero entry ----------------
        b_we = '0;
        b_wr(0, 5'd0, 32'hFFFF);
        b_wr(1, 5'd0, 32'hEEEE);
        b_raddr[4:0] = 5'd0;
        #1;
        check("zero_bypass", b_rdata[31:0], 32'd0);
        tick();
        b_we = '0;
        #1;
        check("zero_stored",   b_rdata[31:0], 32'd0);
        check("zero_conflict", {31'd0, b_wr_conflict}, 32'd1);

        // ---------------- Out-of-range on DEPTH=20 ----------------
        b_we = '0;
        b_wr(0, 5'd25, 32'h1234);
        b_wr(1, 5'd25, 32'h5678);
        b_raddr[9:5] = 5'd25;
        #1;
        check("oor_bypass", b_rdata[63:32], 32'd0);
        tick();
        b_we = '0;
        #1;
        check("oor_read",     b_rdata[63:32], 32'd0);
        check("oor_conflict", {31'd0, b_wr_conflict}, 32'd0);

        // ---------------- Bulk clear (instance A) ----------------
        for (int r = 0; r < 8; r++) begin
            a_we = '0;
            for (int k = 0; k < 4; k++) begin
                a_wr(k, 5'(r*4 + k), 32'h100 + 32'(r*4 + k));
            end
            tick();
        end
        a_we = '0;
        a_raddr[4:0] = 5'd0;
        a_raddr[9:5] = 5'd31;
        #1;
        check("fill_e0",  a_rdata[31:0],  32'h100);
        check("fill_e31", a_rdata[63:32], 32'h11F);

        // Write and clr_start in the same idle cycle
        a_wr(0, 5'd2, 32'h999);
        a_clr_start = 1'b1;
        busy_cnt = 0;
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (a_busy)     busy_cnt++;
            if (a_clr_done) done_cnt++;
            if (c == 0) begin
                a_clr_start = 1'b0;
                a_we = '0;
                a_wr(0, 5'd31, 32'h777);
                a_wr(1, 5'd31, 32'h888);
                a_raddr[4:0] = 5'd2;
                a_raddr[9:5] = 5'd31;
                #1;
                check("clr_wr_committed", a_rdata[31:0],  32'h999);
                check("clr_no_bypass",    a_rdata[63:32], 32'h11F);
            end else if (c == 1) begin
                a_we = '0;
                #1;
                check("clr_conflict_held", {31'd0, a_wr_conflict}, 32'd0);
            end else if (c == 3) begin
                a_clr_start = 1'b1;
            end else if (c == 4) begin
                a_clr_start = 1'b0;
            end else begin
                if (c == 5) begin
                    #1;
                    check("clr_partial",  a_rdata[31:0],  32'd0);
                    check("clr_dropped",  a_rdata[63:32], 32'h11F);
                end
                // Request another clear during the DONE cycle; must be ignored
                a_clr_start = a_clr_done;
            end
        end
        a_clr_start = 1'b0;
        check("clr_busy_cycles", 32'(busy_cnt), 32'd32);
        check("clr_done_pulses", 32'(done_cnt), 32'd1);
        check("clr_idle_after",  {31'd0, a_busy}, 32'd0);
        acc = '0;
        for (int e = 0; e < 32; e++) begin
            a_raddr[4:0] = 5'(e);
            #1;
            acc = acc | a_rdata[31:0];
        end
        check("clr_all_zero", acc, 32'd0);

        // ---------------- Reset mid-clear ----------------
        a_we = '0;
        a_wr(0, 5'd20, 32'hA0);
        a_wr(1, 5'd21, 32'hA1);
        a_wr(2, 5'd22, 32'hA2);
        a_wr(3, 5'd23, 32'hA3);
        tick();
        a_we = '0;
        a_clr_start = 1'b1;
        tick();
        a_clr_start = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        a_raddr[4:0] = 5'd20;
        a_raddr[9:5] = 5'd23;
        #1;
        check("mid_busy",     {31'd0, a_busy}, 32'd1);
        check("mid_e20_kept", a_rdata[31:0],   32'hA0);
        a_reset = 1'b1;
        #1;
        check("mid_rst_busy", {31'd0, a_busy},     32'd0);
        check("mid_rst_done", {31'd0, a_clr_done}, 32'd0);
        check("mid_rst_e20",  a_rdata[31:0],       32'd0);
        check("mid_rst_e23",  a_rdata[63:32],      32'd0);
        tick();
        a_reset = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (a_busy)     busy_cnt++;
            if (a_clr_done) done_cnt++;
        end
        check("mid_no_done", 32'(done_cnt), 32'd0);
        check("mid_no_busy", 32'(busy_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-write, multi-read register file. It is the next generation of the team's fixed 32x32 four-write/two-read file.
- Adds configurable width, depth and port counts.
- Adds deterministic write priority, optional write-to-read bypass, an optional hardwired-zero entry, collision reporting, and a sequenced bulk-clear engine.
- Sits beside the datapath as the architectural register store.

Parameters:
WIDTH, 32, data bits per entry
DEPTH, 32, number of entries (2..256, need not be a power of 2)
NW, 4, number of write ports (1..8)
NR, 2, number of read ports (1..8)
BYPASS, 1, 1 = read ports forward same-cycle write data; 0 = read returns stored value only
ZERO_REG, 0, 1 = entry 0 always reads 0 and ignores writes
AW (localparam), clog2(DEPTH), address width

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous, active-high reset
we  in  NW  per-port write enable; port k uses bit k
waddr  in  NW*AW  write addresses; port k uses slice [k*AW +: AW]
wdata  in  NW*WIDTH  write data; port k uses slice [k*WIDTH +: WIDTH]
raddr  in  NR*AW  read addresses; port j uses slice [j*AW +: AW]
rdata  out  NR*WIDTH  read data; combinational
clr_start  in  1  request a bulk clear of all entries
busy  out  1  high while the clear engine runs
clr_done  out  1  one-cycle pulse when the clear completes
wr_conflict  out  1  registered flag for a same-address write collision

Behaviour:
- Reset (asynchronous):
  - All entries go to 0.
  - FSM goes to IDLE and the clear counter to 0.
  - busy, clr_done and wr_conflict all read 0.
- Write, when not busy:
  - Each port k with we[k]=1 and waddr_k < DEPTH updates its entry at the clock edge.
  - Addresses >= DEPTH are ignored.
- Write priority: when several enabled ports hit the same entry, the highest port index wins. All other entries are written in parallel.
- wr_conflict:
  - Set at the edge following any cycle in which two or more enabled, in-range ports target the same address, with busy=0.
  - Otherwise 0 next cycle, so one cycle of collision gives a one-cycle pulse.
  - Collisions on entry 0 with ZERO_REG=1 still flag.
- Read:
  - rdata_j is the entry at raddr_j, combinationally.
  - raddr_j >= DEPTH returns 0.
  - ZERO_REG=1 and raddr_j = 0 returns 0.
- Bypass (BYPASS=1, busy=0): if any enabled, in-range write port targets raddr_j in the current cycle, rdata_j is the winning port's wdata. The ZERO_REG rule overrides bypass.
- Clear FSM:
  - IDLE: clr_start=1 moves to CLEAR, counter = 0, busy=1 from the next cycle.
  - CLEAR: one entry cleared per cycle at index counter, then counter increments. After index DEPTH-1 is cleared, move to DONE.
  - DONE: clr_done=1 and busy=0 for exactly one cycle, then return to IDLE.
  - Total: DEPTH cycles of busy, then one cycle of clr_done.
- While busy:
  - User writes are dropped and wr_conflict is held 0.
  - Reads return stored values with no bypass. Already-cleared entries read 0.
  - clr_start is ignored.
  - clr_start during DONE is also ignored.
- Write and clr_start in the same IDLE cycle: the write commits, and the clear starts next cycle and later zeroes that entry too.
- Reset mid-clear: immediate return to IDLE with all entries 0. No clr_done pulse.

Decomposition:
- Shared package holds:
  - clear FSM state encoding (IDLE, CLEAR, DONE)
  - a clog2 helper function
- Natural sub-module: regfile_wr_arb.
  - Per-entry priority arbiter over NW ports.
  - Outputs a write strobe and the selected data for one entry.
  - Instantiated DEPTH times under a generate loop.
- Collision detection and the bypass mux stay in the top level.

Test Plan:
- Reset, then single write: assert reset, release, write port 0 addr 5 data 0xDEADBEEF -> raddr0=5 reads 0 before the edge with BYPASS=0, 0xDEADBEEF after.
- Four-way collision: we=4'b1111, all addresses 7, data 1/2/3/4 -> entry 7 = 4, wr_conflict=1 for exactly the next cycle. Distinct addresses next cycle -> wr_conflict=0.
- Bypass: BYPASS=1, port 2 writes addr 3 = 0x55 while raddr1=3 -> rdata1 = 0x55 in the same cycle.
- ZERO_REG=1: write addr 0 = 0xFFFF -> raddr0=0 reads 0, with or without bypass.
- Bulk clear: fill all 32 entries with nonzero values, pulse clr_start -> busy high for 32 cycles. Writes during busy are dropped. clr_done pulses once. All entries read 0 afterwards.
- Reset mid-clear: assert reset at clear cycle 10 -> busy=0 immediately, all entries 0, no clr_done. Out-of-range read with DEPTH=20 at raddr=25 -> 0.
